// File: rtl/vehicle_detect_conditioner.sv
// Loop-sensor conditioner for the traffic core: per direction a 2-flop
// synchronizer, a consecutive-sample debouncer and a request FSM that keeps
// the vehicle request alive until green serves it, plus a short tail.

module vehicle_detect_lane #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int HOLD_CYCLES     = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sensor_raw,
  input  logic green,
  output logic vehicle_detect,
  output logic stable
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, PENDING, SERVING, HOLD} req_state_t;

  logic          sync_meta;
  logic          sync_q;
  logic [CW-1:0] deb_cnt;
  logic [HW-1:0] hold_cnt;
  logic [HW-1:0] hold_next;
  req_state_t    state;
  req_state_t    state_next;

  // Two-flop synchronizer for the asynchronous, glitchy loop sensor
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_meta <= 1'b0;
      sync_q    <= 1'b0;
    end else begin
      sync_meta <= sensor_raw;
      sync_q    <= sync_meta;
    end
  end

  // Flip the stable level only after DEBOUNCE_CYCLES consecutive differing samples
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stable  <= 1'b0;
      deb_cnt <= '0;
    end else if (sync_q == stable) begin
      deb_cnt <= '0;
    end else if (deb_cnt == CNT_LAST) begin
      stable  <= sync_q;
      deb_cnt <= '0;
    end else begin
      deb_cnt <= deb_cnt + CW'(1);
    end
  end

  // Request FSM next state; checks are ordered by priority within each state
  always_comb begin
    state_next = state;
    hold_next  = hold_cnt;
    case (state)
      IDLE: begin
        if (stable && green) state_next = SERVING;
        else if (stable)     state_next = PENDING;
      end
      PENDING: begin
        if (green)        state_next = SERVING;
        else if (!stable) state_next = IDLE;
      end
      SERVING: begin
        if (!green) begin
          state_next = stable ? PENDING : IDLE;
        end else if (!stable) begin
          state_next = HOLD;
          hold_next  = HOLD_LAST;
        end
      end
      HOLD: begin
        if (!green)               state_next = IDLE;
        else if (stable)          state_next = SERVING;
        else if (hold_cnt == '0)  state_next = IDLE;
        else                      hold_next  = hold_cnt - HW'(1);
      end
      default: state_next = IDLE;
    endcase
  end

  // State, tail counter and registered request output
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      hold_cnt       <= '0;
      vehicle_detect <= 1'b0;
    end else begin
      state          <= state_next;
      hold_cnt       <= hold_next;
      vehicle_detect <= (state_next != IDLE);
    end
  end

endmodule

module vehicle_detect_conditioner #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int HOLD_CYCLES     = 8
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_ns_sensor_raw,
  input  logic i_ew_sensor_raw,
  input  logic i_ns_green,
  input  logic i_ew_green,
  output logic o_ns_vehicle_detect,
  output logic o_ew_vehicle_detect,
  output logic o_ns_stable,
  output logic o_ew_stable
);

  vehicle_detect_lane #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .HOLD_CYCLES     (HOLD_CYCLES)
  ) u_ns_lane (
    .clk            (i_clk),
    .rst_n          (i_rst_n),
    .sensor_raw     (i_ns_sensor_raw),
    .green          (i_ns_green),
    .vehicle_detect (o_ns_vehicle_detect),
    .stable         (o_ns_stable)
  );

  vehicle_detect_lane #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .HOLD_CYCLES     (HOLD_CYCLES)
  ) u_ew_lane (
    .clk            (i_clk),
    .rst_n          (i_rst_n),
    .sensor_raw     (i_ew_sensor_raw),
    .green          (i_ew_green),
    .vehicle_detect (o_ew_vehicle_detect),
    .stable         (o_ew_stable)
  );

endmodule

// File: tb/tb_vehicle_detect_conditioner.sv
// Self-checking bench for vehicle_detect_conditioner: directed scenarios and
// randomized sensor/green traffic compared against a cycle-level reference model.

module tb_vehicle_detect_conditioner;

  localparam int DEB  = 4;
  localparam int HOLD = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ns_raw = 1'b0, ew_raw = 1'b0;
  logic ns_green = 1'b0, ew_green = 1'b0;
  logic ns_det, ew_det, ns_stb, ew_stb;

  int testsRun = 0;
  int testsFailed = 0;

  // Reference model, lane 0 = NS, lane 1 = EW.
  // req: 0 no request, 1 waiting for green, 2 being served, 3 post-vehicle tail
  bit m_hist[2][2];
  bit m_stable[2];
  int m_run[2];
  int m_req[2];
  int m_tail[2];
  bit m_det[2];

  vehicle_detect_conditioner #(
    .DEBOUNCE_CYCLES (DEB),
    .HOLD_CYCLES     (HOLD)
  ) dut (
    .i_clk               (clk),
    .i_rst_n             (rst_n),
    .i_ns_sensor_raw     (ns_raw),
    .i_ew_sensor_raw     (ew_raw),
    .i_ns_green          (ns_green),
    .i_ew_green          (ew_green),
    .o_ns_vehicle_detect (ns_det),
    .o_ew_vehicle_detect (ew_det),
    .o_ns_stable         (ns_stb),
    .o_ew_stable         (ew_stb)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic obs, input logic exp);
    testsRun++;
    if (obs !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0b expected %0b at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic modelReset();
    for (int l = 0; l < 2; l++) begin
      m_hist[l][0] = 0; m_hist[l][1] = 0;
      m_stable[l] = 0; m_run[l] = 0;
      m_req[l] = 0; m_tail[l] = 0; m_det[l] = 0;
    end
  endtask

  task automatic modelClock();
    bit raw[2];
    bit grn[2];
    bit seen;
    bit sampled;
    raw[0] = ns_raw; raw[1] = ew_raw;
    grn[0] = ns_green; grn[1] = ew_green;
    for (int l = 0; l < 2; l++) begin
      seen    = m_stable[l];
      sampled = m_hist[l][1];
      if (m_req[l] == 0) begin
        if (seen) m_req[l] = grn[l] ? 2 : 1;
      end else if (m_req[l] == 1) begin
        if (grn[l]) m_req[l] = 2;
        else if (!seen) m_req[l] = 0;
      end else if (m_req[l] == 2) begin
        if (!grn[l]) m_req[l] = seen ? 1 : 0;
        else if (!seen) begin m_req[l] = 3; m_tail[l] = HOLD - 1; end
      end else begin
        if (!grn[l]) m_req[l] = 0;
        else if (seen) m_req[l] = 2;
        else if (m_tail[l] == 0) m_req[l] = 0;
        else m_tail[l]--;
      end
      m_det[l] = (m_req[l] != 0);
      // count the run of consecutive samples disagreeing with the stable level
      if (sampled == seen) m_run[l] = 0;
      else begin
        m_run[l]++;
        if (m_run[l] == DEB) begin m_stable[l] = sampled; m_run[l] = 0; end
      end
      m_hist[l][1] = m_hist[l][0];
      m_hist[l][0] = raw[l];
    end
  endtask

  task automatic checkAll(input string tag);
    checkOutput({tag, "_ns_stable"}, ns_stb, m_stable[0]);
    checkOutput({tag, "_ew_stable"}, ew_stb, m_stable[1]);
    checkOutput({tag, "_ns_detect"}, ns_det, m_det[0]);
    checkOutput({tag, "_ew_detect"}, ew_det, m_det[1]);
  endtask

  // Drive one cycle of inputs, clock, advance the model and compare
  task automatic applyStimulus(input logic nr, input logic er, input logic ng, input logic eg,
                               input string tag);
    ns_raw = nr; ew_raw = er; ns_green = ng; ew_green = eg;
    @(posedge clk);
    if (rst_n) modelClock();
    else modelReset();
    #1;
    checkAll(tag);
  endtask

  task automatic pulseReset(input string tag);
    #2;
    rst_n = 1'b0;
    modelReset();
    #1;
    checkOutput({tag, "_ns_detect_async"}, ns_det, 1'b0);
    checkOutput({tag, "_ew_detect_async"}, ew_det, 1'b0);
    checkOutput({tag, "_ns_stable_async"}, ns_stb, 1'b0);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic reacquire(input string tag);
    for (int c = 1; c <= 7; c++) begin
      applyStimulus(1, 1, 0, 0, tag);
      checkOutput($sformatf("%s_c%0d_ns_stable", tag, c), ns_stb, (c >= 6));
      checkOutput($sformatf("%s_c%0d_ew_detect", tag, c), ew_det, (c >= 7));
    end
  endtask

  initial begin
    int nsLeft, ewLeft, ngLeft, egLeft;
    logic nr, er, ng, eg;

    modelReset();
    // Reset held with sensors asserted: nothing may propagate
    for (int c = 0; c < 4; c++) applyStimulus(1, 1, 0, 0, "rst_hold");
    @(negedge clk);
    rst_n = 1'b1;
    reacquire("acq");

    // Vehicles leave, back to idle
    for (int c = 0; c < 12; c++) applyStimulus(0, 0, 0, 0, "clear");

    // 3-cycle glitch is filtered; 4-cycle glitch makes a brief request
    for (int c = 0; c < 3; c++) applyStimulus(1, 0, 0, 0, "glitch3");
    for (int c = 0; c < 10; c++) begin
      applyStimulus(0, 0, 0, 0, "glitch3_after");
      checkOutput("glitch3_no_detect", ns_det, 1'b0);
    end
    for (int c = 0; c < 4; c++) applyStimulus(1, 0, 0, 0, "glitch4");
    for (int c = 0; c < 14; c++) applyStimulus(0, 0, 0, 0, "glitch4_after");

    // EW served then tail hold after the vehicle leaves
    for (int c = 0; c < 17; c++) applyStimulus(0, 1, 0, 0, "ew_wait");
    for (int c = 0; c < 5; c++) applyStimulus(0, 1, 0, 1, "ew_serve");
    for (int c = 0; c < 20; c++) applyStimulus(0, 0, 0, 1, "ew_tail");
    applyStimulus(0, 0, 0, 0, "ew_done");
    checkOutput("ew_tail_expired", ew_det, 1'b0);

    // NS green drops while vehicle waits, then returns
    for (int c = 0; c < 8; c++) applyStimulus(1, 0, 1, 0, "ns_serve");
    for (int c = 0; c < 4; c++) begin
      applyStimulus(1, 0, 0, 0, "ns_pending");
      checkOutput("ns_no_gap", ns_det, 1'b1);
    end
    for (int c = 0; c < 3; c++) applyStimulus(1, 0, 1, 0, "ns_reserve");

    // Re-arrival during the tail, then green drop during the tail
    for (int c = 0; c < 9; c++) applyStimulus(0, 0, 1, 0, "ns_hold");
    for (int c = 0; c < 8; c++) applyStimulus(1, 0, 1, 0, "ns_rearrive");
    for (int c = 0; c < 9; c++) applyStimulus(0, 0, 1, 0, "ns_hold2");
    applyStimulus(0, 0, 0, 0, "ns_hold_drop");
    applyStimulus(0, 0, 0, 0, "ns_hold_drop2");
    checkOutput("ns_hold_green_drop", ns_det, 1'b0);

    // Async reset while both lanes are served, then re-acquire
    for (int c = 0; c < 10; c++) applyStimulus(1, 1, 1, 1, "both_serve");
    pulseReset("mid_rst");
    reacquire("reacq");

    // Randomized traffic with occasional asynchronous resets
    nr = 0; er = 0; ng = 0; eg = 0;
    nsLeft = 0; ewLeft = 0; ngLeft = 0; egLeft = 0;
    for (int c = 0; c < 4000; c++) begin
      if (nsLeft == 0) begin nr = ~nr; nsLeft = $urandom_range(1, 14); end
      if (ewLeft == 0) begin er = ~er; ewLeft = $urandom_range(1, 14); end
      if (ngLeft == 0) begin ng = ~ng; ngLeft = $urandom_range(1, 30); end
      if (egLeft == 0) begin eg = ~eg; egLeft = $urandom_range(1, 30); end
      nsLeft--; ewLeft--; ngLeft--; egLeft--;
      applyStimulus(nr, er, ng, eg, "rand");
      if ($urandom_range(0, 499) == 0) pulseReset("rand_rst");
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
